// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-memory requesters plus the memory-side strobes.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [2:0]        a_func3;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [2:0]        b_func3;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_func3, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_func3, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_func3, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_func3, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant in IDLE, one-cycle memory access, one-cycle ack (req->ack 2 cycles, 1 op / 3 cycles).
// No backpressure: requesters hold req until ack; inputs are ignored outside IDLE, misaligned/illegal ops never strobe memory.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = A, 1 = B
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              grant_b;
  logic              sel_we;
  logic [2:0]        sel_func3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] ld_data;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (!we && ((f3 == 3'b100) || (f3 == 3'b101)));
    return !legal || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  // On a tie, round-robin hands the grant to whichever port was not served last.
  assign grant_b   = bus.b_req && (!bus.a_req || (!FIXED_PRIO && !last_q));
  assign sel_we    = grant_b ? bus.b_we    : bus.a_we;
  assign sel_func3 = grant_b ? bus.b_func3 : bus.a_func3;
  assign sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
  assign ld_data   = (!we_q && !err_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      func3_q   <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      func3_q   <= func3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    func3_d   = func3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          owner_d = grant_b;
          we_d    = sel_we;
          func3_d = sel_func3;
          addr_d  = sel_addr;
          wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
          err_d   = access_err(sel_we, sel_func3, sel_addr[1:0]);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (owner_q) b_rdata_d = ld_data;
        else         a_rdata_d = ld_data;
        state_d = RESP;
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode only from registered state, so req can never reach memory combinationally.
  assign bus.mem_read  = (state_q == ACCESS) && !we_q && !err_q;
  assign bus.mem_write = (state_q == ACCESS) &&  we_q && !err_q;
  assign bus.mem_func3 = func3_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.a_ack   = (state_q == RESP) && !owner_q;
  assign bus.b_ack   = (state_q == RESP) &&  owner_q;
  assign bus.a_err   = bus.a_ack && err_q;
  assign bus.b_err   = bus.b_ack && err_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and fixed-priority instances, byte-addressed memory model,
// expected responses queued at issue time and checked by per-instance ack monitors.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(bus0));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  function automatic logic [31:0] mem_load(input logic [2:0] f3, input logic [7:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[a];
    h = {mem[a+8'd1], mem[a]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {mem[a+8'd3], mem[a+8'd2], h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Memory model for the round-robin instance; the fixed-priority instance reads zeros.
  always @(negedge clk) bus0.mem_rdata = mem_load(bus0.mem_func3, bus0.mem_addr);
  assign bus1.mem_rdata = '0;

  always @(posedge clk) begin
    if (bus0.mem_write) begin
      mem[bus0.mem_addr] <= bus0.mem_wdata[7:0];
      if (bus0.mem_func3[1:0] != 2'b00) mem[bus0.mem_addr+8'd1] <= bus0.mem_wdata[15:8];
      if (bus0.mem_func3[1:0] == 2'b10) begin
        mem[bus0.mem_addr+8'd2] <= bus0.mem_wdata[23:16];
        mem[bus0.mem_addr+8'd3] <= bus0.mem_wdata[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.mem_read && bus0.mem_write) begin
      checks++; errors++;
      $display("FAIL rr_strobes_exclusive: mem_read=1 mem_write=1, expected at most one");
    end
    if (!rst && (bus0.a_ack || bus0.b_ack)) begin
      chk("rr_ack_exclusive", {31'b0, bus0.a_ack && bus0.b_ack}, 32'h0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected_ack: a_ack=%b b_ack=%b, expected no ack", bus0.a_ack, bus0.b_ack);
      end else begin
        e0 = q0.pop_front();
        chk("rr_port", {31'b0, bus0.b_ack}, {31'b0, e0.port});
        chk("rr_err", {31'b0, e0.port ? bus0.b_err : bus0.a_err}, {31'b0, e0.err});
        chk("rr_other_err", {31'b0, e0.port ? bus0.a_err : bus0.b_err}, 32'h0);
        chk("rr_rdata", e0.port ? bus0.b_rdata : bus0.a_rdata, e0.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (bus1.a_ack || bus1.b_ack)) begin
      chk("fp_ack_exclusive", {31'b0, bus1.a_ack && bus1.b_ack}, 32'h0);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL fp_unexpected_ack: a_ack=%b b_ack=%b, expected no ack", bus1.a_ack, bus1.b_ack);
      end else begin
        e1 = q1.pop_front();
        chk("fp_port", {31'b0, bus1.b_ack}, {31'b0, e1.port});
        chk("fp_err", {31'b0, e1.port ? bus1.b_err : bus1.a_err}, {31'b0, e1.err});
        chk("fp_rdata", e1.port ? bus1.b_rdata : bus1.a_rdata, e1.rdata);
      end
    end
  end

  task automatic set_req(input bit port, input bit val, input bit we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd);
    if (!port) begin
      bus0.a_req = val; bus0.a_we = we; bus0.a_func3 = f3; bus0.a_addr = addr; bus0.a_wdata = wd;
    end else begin
      bus0.b_req = val; bus0.b_we = we; bus0.b_func3 = f3; bus0.b_addr = addr; bus0.b_wdata = wd;
    end
  endtask

  // One isolated transaction on the round-robin instance, entered and left on a falling edge.
  task automatic xact(input string name, input bit port, input bit we, input logic [2:0] f3,
                      input logic [7:0] addr, input logic [31:0] wd, input bit exp_err,
                      input logic [31:0] exp_rd);
    int n = 0;
    int rd = 0;
    int wr = 0;
    bit ack = 1'b0;
    @(negedge clk);
    q0.push_back({port, exp_err, exp_rd});
    set_req(port, 1'b1, we, f3, addr, wd);
    do begin
      @(negedge clk);
      n++;
      if (bus0.mem_read)  rd++;
      if (bus0.mem_write) wr++;
      ack = port ? bus0.b_ack : bus0.a_ack;
    end while (!ack && n < 10);
    set_req(port, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    chk({name, "_latency"}, n, 2);
    chk({name, "_rd_cycles"}, rd, (!we && !exp_err) ? 1 : 0);
    chk({name, "_wr_cycles"}, wr, (we && !exp_err) ? 1 : 0);
  endtask

  // Both ports load continuously on the round-robin instance until `want` acks have been seen.
  task automatic both0(input string name, input int want);
    int n = 0;
    int acks = 0;
    int last = -1;
    set_req(1'b0, 1'b1, 1'b0, 3'b010, 8'd16, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 3'b010, 8'd20, 32'h0);
    while (acks < want && n < 40) begin
      @(negedge clk);
      n++;
      if (bus0.a_ack || bus0.b_ack) begin
        acks++;
        if (last >= 0) chk({name, "_ack_spacing"}, n - last, 3);
        last = n;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    chk({name, "_ack_count"}, acks, want);
  endtask

  initial begin
    int n;
    int a_acks;
    bit b_done;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[4]  = 8'hF0;
    {mem[15], mem[14], mem[13], mem[12]} = 32'hAAAA_5555;
    {mem[19], mem[18], mem[17], mem[16]} = 32'h1111_2222;
    {mem[23], mem[22], mem[21], mem[20]} = 32'h3333_4444;
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_func3 = 3'b010; bus1.a_addr = 8'h00; bus1.a_wdata = 32'h0;
    bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_func3 = 3'b010; bus1.b_addr = 8'h00; bus1.b_wdata = 32'h0;

    @(negedge clk);
    chk("reset_acks", {30'b0, bus0.a_ack, bus0.b_ack}, 32'h0);
    chk("reset_strobes", {30'b0, bus0.mem_read, bus0.mem_write}, 32'h0);
    chk("reset_mem_addr", {24'h0, bus0.mem_addr}, 32'h0);
    chk("reset_a_rdata", bus0.a_rdata, 32'h0);
    chk("reset_b_rdata", bus0.b_rdata, 32'h0);
    rst = 1'b0;

    xact("a_lb", 1'b0, 1'b0, 3'b000, 8'd4, 32'h0, 1'b0, 32'hFFFF_FFF0);
    xact("b_sw", 1'b1, 1'b1, 3'b010, 8'd8, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("b_sw_mem_word", word_at(8), 32'hDEAD_BEEF);
    xact("b_lw", 1'b1, 1'b0, 3'b010, 8'd8, 32'h0, 1'b0, 32'hDEAD_BEEF);
    chk("a_rdata_hold", bus0.a_rdata, 32'hFFFF_FFF0);
    xact("a_lw_mis", 1'b0, 1'b0, 3'b010, 8'd2, 32'h0, 1'b1, 32'h0);
    xact("b_lh_mis", 1'b1, 1'b0, 3'b001, 8'd5, 32'h0, 1'b1, 32'h0);
    xact("a_f3_011", 1'b0, 1'b0, 3'b011, 8'd0, 32'h0, 1'b1, 32'h0);
    xact("a_st_f3_100", 1'b0, 1'b1, 3'b100, 8'd0, 32'h5A, 1'b1, 32'h0);
    chk("illegal_store_no_commit", word_at(0), 32'h0);
    xact("a_lhu", 1'b0, 1'b0, 3'b101, 8'd4, 32'h0, 1'b0, 32'h0000_00F0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q0.push_back({1'b0, 1'b0, 32'h1111_2222});
    q0.push_back({1'b1, 1'b0, 32'h3333_4444});
    q0.push_back({1'b0, 1'b0, 32'h1111_2222});
    q0.push_back({1'b1, 1'b0, 32'h3333_4444});
    both0("rr", 4);

    @(negedge clk);
    q1.push_back({1'b0, 1'b0, 32'h0});
    q1.push_back({1'b0, 1'b0, 32'h0});
    q1.push_back({1'b0, 1'b0, 32'h0});
    q1.push_back({1'b1, 1'b0, 32'h0});
    bus1.a_req = 1'b1;
    bus1.b_req = 1'b1;
    n = 0; a_acks = 0; b_done = 1'b0;
    while (!b_done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus1.a_ack) begin
        a_acks++;
        if (a_acks == 3) bus1.a_req = 1'b0;
      end
      if (bus1.b_ack) b_done = 1'b1;
    end
    bus1.a_req = 1'b0;
    bus1.b_req = 1'b0;
    chk("fp_a_acks", a_acks, 3);
    chk("fp_b_served", {31'b0, b_done}, 32'h1);

    xact("a_lb_pre_rst", 1'b0, 1'b0, 3'b000, 8'd4, 32'h0, 1'b0, 32'hFFFF_FFF0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 3'b010, 8'd12, 32'h1234_5678);
    @(negedge clk);
    chk("rst_wr_in_access", {31'b0, bus0.mem_write}, 32'h1);
    #2 rst = 1'b1;
    #1 chk("rst_wr_dropped", {31'b0, bus0.mem_write}, 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    @(negedge clk);
    chk("rst_no_ack", {30'b0, bus0.a_ack, bus0.b_ack}, 32'h0);
    @(negedge clk); rst = 1'b0;
    chk("rst_no_commit", word_at(12), 32'hAAAA_5555);
    q0.push_back({1'b0, 1'b0, 32'h1111_2222});
    q0.push_back({1'b1, 1'b0, 32'h3333_4444});
    both0("post_rst", 2);

    repeat (4) @(negedge clk);
    chk("rr_queue_drained", q0.size(), 0);
    chk("fp_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
